square_renderer: RTL and testbench

SQUARE_RENDERER -- requirements
Module: square_renderer

---
 rtl/square_renderer_pkg.sv | 57 +++++
 rtl/square_renderer_glyph.sv | 37 +++
 rtl/square_renderer.sv | 171 +++++++++++++++++
 tb/tb_square_renderer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/square_renderer_pkg.sv
// ============================================================================
// Module : square_renderer_pkg
// Brief  : Shared piece codes, colours, FSM states and request record for the
//          chess-square renderer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package square_renderer_pkg;

  localparam int SQ_SIZE = 15;

  localparam logic [3:0] EMPTY    = 4'd0;
  localparam logic [3:0] B_PAWN   = 4'd1;
  localparam logic [3:0] B_KNIGHT = 4'd2;
  localparam logic [3:0] B_BISHOP = 4'd3;
  localparam logic [3:0] B_ROOK   = 4'd4;
  localparam logic [3:0] B_QUEEN  = 4'd5;
  localparam logic [3:0] B_KING   = 4'd6;
  localparam logic [3:0] W_PAWN   = 4'd7;
  localparam logic [3:0] W_KNIGHT = 4'd8;
  localparam logic [3:0] W_BISHOP = 4'd9;
  localparam logic [3:0] W_ROOK   = 4'd10;
  localparam logic [3:0] W_QUEEN  = 4'd11;
  localparam logic [3:0] W_KING   = 4'd12;

  localparam logic [2:0] COL_LIGHT = 3'b110;
  localparam logic [2:0] COL_DARK  = 3'b011;
  localparam logic [2:0] COL_BLACK = 3'b001;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] sq_x;
    logic [2:0] sq_y;
    logic [3:0] piece;
  } req_t;

  function automatic logic is_piece(input logic [3:0] p);
    return (p >= B_PAWN) && (p <= W_KING);
  endfunction

  // Glyph index 0..5 (pawn..king) shared by both colours.
  function automatic logic [2:0] glyph_of(input logic [3:0] p);
    if (p >= W_PAWN) return 3'(p - W_PAWN);
    return 3'(p - B_PAWN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/square_renderer_glyph.sv
// ============================================================================
// Module : piece_glyph_rom
// Brief  : Combinational 9x9 piece bitmaps; bit c of a row is glyph column c.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module piece_glyph_rom (
  input  logic [2:0] glyph_type,
  input  logic [3:0] row,
  output logic [8:0] row_bits
);

  localparam logic [8:0] GLYPH [6][9] = '{
    '{9'b000000000, 9'b000111000, 9'b000111000, 9'b000010000, 9'b000111000,
      9'b000111000, 9'b001111100, 9'b011111110, 9'b000000000},
    '{9'b000011000, 9'b000111100, 9'b001111110, 9'b011110110, 9'b011110000,
      9'b001111000, 9'b001111100, 9'b011111110, 9'b000000000},
    '{9'b000010000, 9'b000111000, 9'b001101100, 9'b001111100, 9'b000111000,
      9'b000111000, 9'b000010000, 9'b011111110, 9'b000000000},
    '{9'b010101010, 9'b011111110, 9'b001111100, 9'b001111100, 9'b001111100,
      9'b001111100, 9'b011111110, 9'b111111111, 9'b000000000},
    '{9'b100010001, 9'b010111010, 9'b011111110, 9'b001111100, 9'b001111100,
      9'b000111000, 9'b011111110, 9'b111111111, 9'b000000000},
    '{9'b000010000, 9'b000111000, 9'b000010000, 9'b001111100, 9'b011111110,
      9'b001111100, 9'b000111000, 9'b011111110, 9'b000000000}
  };

  always_comb begin
    row_bits = '0;
    if (glyph_type < 3'd6 && row < 4'd9)
      row_bits = GLYPH[glyph_type][row];
  end

endmodule

`default_nettype wire

// File: rtl/square_renderer.sv
// ============================================================================
// Module : square_renderer
// Brief  : Buffers board-square writes in a 2-deep FIFO and rasterises each
//          square (background plus piece glyph) into VGA pixel writes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module square_renderer #(
  parameter int         SQ_SIZE  = square_renderer_pkg::SQ_SIZE,
  parameter int         BOARD_X0 = 20,
  parameter logic [2:0] C_LIGHT  = square_renderer_pkg::COL_LIGHT,
  parameter logic [2:0] C_DARK   = square_renderer_pkg::COL_DARK,
  parameter logic [2:0] C_BLACK  = square_renderer_pkg::COL_BLACK,
  parameter logic [2:0] C_WHITE  = square_renderer_pkg::COL_WHITE
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_en,
  input  logic [2:0] sq_x,
  input  logic [2:0] sq_y,
  input  logic [3:0] piece,
  output logic       ready,
  output logic       plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       done,
  output logic       overflow
);

  import square_renderer_pkg::*;

  localparam int             CW   = $clog2(SQ_SIZE);
  localparam logic [CW-1:0]  LAST = CW'(SQ_SIZE - 1);

  req_t          fifo_mem [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    count;
  state_t        state;
  req_t          work;
  logic [7:0]    base_x;
  logic [6:0]    base_y;
  logic [CW-1:0] px, py;

  logic          push, pop, last_pix, glyph_hit;
  req_t          head, incoming, cur;
  logic [7:0]    cbx;
  logic [6:0]    cby;
  logic [CW-1:0] nx, ny;
  logic [3:0]    gcol, grow;
  logic [2:0]    gtype, pix_colour;
  logic [8:0]    gbits;

  assign ready    = (count < 2'd2);
  assign push     = wr_en && ready;
  assign pop      = (state == S_LOAD);
  assign head     = fifo_mem[rd_ptr];
  assign incoming = '{sq_x: sq_x, sq_y: sq_y, piece: piece};
  assign last_pix = (px == LAST) && (py == LAST);

  // Outputs are registered, so this block works out the pixel that will be
  // presented in the next cycle: (0,0) of the FIFO head while loading, else
  // the raster successor of the current pixel.
  always_comb begin
    cur = work;
    cbx = base_x;
    cby = base_y;
    nx  = '0;
    ny  = '0;
    if (state == S_LOAD) begin
      cur = head;
      cbx = 8'(BOARD_X0) + 8'(head.sq_x) * 8'(SQ_SIZE);
      cby = 7'(head.sq_y) * 7'(SQ_SIZE);
    end else if (px == LAST) begin
      ny = py + 1'b1;
    end else begin
      nx = px + 1'b1;
      ny = py;
    end
  end

  assign gtype = glyph_of(cur.piece);
  assign gcol  = 4'(nx) - 4'd3;
  assign grow  = 4'(ny) - 4'd3;

  piece_glyph_rom u_glyph_rom (
    .glyph_type (gtype),
    .row        (grow),
    .row_bits   (gbits)
  );

  assign glyph_hit = is_piece(cur.piece)
                   && (nx >= CW'(3)) && (nx <= CW'(11))
                   && (ny >= CW'(3)) && (ny <= CW'(11))
                   && gbits[gcol];

  assign pix_colour = glyph_hit ? ((cur.piece >= W_PAWN) ? C_WHITE : C_BLACK)
                                : ((cur.sq_x[0] ^ cur.sq_y[0]) ? C_DARK : C_LIGHT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      state    <= S_IDLE;
      work     <= '0;
      base_x   <= '0;
      base_y   <= '0;
      px       <= '0;
      py       <= '0;
      plot     <= 1'b0;
      vga_x    <= '0;
      vga_y    <= '0;
      colour   <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= incoming;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (wr_en && !ready) overflow <= 1'b1;

      done <= 1'b0;
      plot <= 1'b0;
      case (state)
        S_IDLE: begin
          // An accepted write at this edge counts, giving LOAD one cycle later.
          if (count != 2'd0 || push) state <= S_LOAD;
        end
        S_LOAD: begin
          work   <= head;
          base_x <= cbx;
          base_y <= cby;
          px     <= '0;
          py     <= '0;
          plot   <= 1'b1;
          vga_x  <= cbx + 8'(nx);
          vga_y  <= cby + 7'(ny);
          colour <= pix_colour;
          state  <= S_DRAW;
        end
        S_DRAW: begin
          if (last_pix) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            px     <= nx;
            py     <= ny;
            plot   <= 1'b1;
            vga_x  <= cbx + 8'(nx);
            vga_y  <= cby + 7'(ny);
            colour <= pix_colour;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_square_renderer.sv
// ============================================================================
// Module : tb_square_renderer
// Brief  : Scoreboard bench for square_renderer with directed square writes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_square_renderer;

  logic       clk, resetn, wr_en;
  logic [2:0] sq_x, sq_y;
  logic [3:0] piece;
  logic       ready, plot, done, overflow;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;

  square_renderer dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .sq_x(sq_x), .sq_y(sq_y),
    .piece(piece), .ready(ready), .plot(plot), .vga_x(vga_x), .vga_y(vga_y),
    .colour(colour), .done(done), .overflow(overflow)
  );

  typedef struct { int x; int y; logic [2:0] c; int cyc; } pix_t;

  pix_t pq[$];
  int   dq[$];
  int   loads[$];
  int   last_done = -100;
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;
  pix_t e;
  int   ed;

  // Column 0 is the leftmost character of each row.
  string glyph [6][9] = '{
    '{".........", "...###...", "...###...", "....#....", "...###...",
      "...###...", "..#####..", ".#######.", "........."},
    '{"...##....", "..####...", ".######..", ".##.####.", "....####.",
      "...####..", "..#####..", ".#######.", "........."},
    '{"....#....", "...###...", "..##.##..", "..#####..", "...###...",
      "...###...", "....#....", ".#######.", "........."},
    '{".#.#.#.#.", ".#######.", "..#####..", "..#####..", "..#####..",
      "..#####..", ".#######.", "#########", "........."},
    '{"#...#...#", ".#.###.#.", ".#######.", "..#####..", "..#####..",
      "...###...", ".#######.", "#########", "........."},
    '{"....#....", "...###...", "....#....", "..#####..", ".#######.",
      "..#####..", "...###...", ".#######.", "........."}
  };

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] exp_colour(int x, int y, int p, int px, int py);
    logic [2:0] c;
    string      r;
    c = ((x + y) % 2 == 1) ? 3'b011 : 3'b110;
    if (p >= 1 && p <= 12 && px >= 3 && px <= 11 && py >= 3 && py <= 11) begin
      r = glyph[(p - 1) % 6][py - 3];
      if (r[px - 3] == "#") c = (p <= 6) ? 3'b001 : 3'b111;
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Drives one write for a single cycle; the bench's own FIFO occupancy model
  // decides whether it is accepted and, if so, queues the whole square.
  task automatic send(int x, int y, int p);
    int   occ;
    int   ld;
    pix_t q;
    bit   exp_rdy;
    occ = 0;
    foreach (loads[i]) if (loads[i] >= cyc) occ++;
    exp_rdy = (occ < 2);
    chk("ready", int'(ready), int'(exp_rdy));
    sq_x  = 3'(x);
    sq_y  = 3'(y);
    piece = 4'(p);
    wr_en = 1'b1;
    if (exp_rdy) begin
      ld = (cyc + 1 > last_done + 2) ? cyc + 1 : last_done + 2;
      loads.push_back(ld);
      for (int py = 0; py < 15; py++)
        for (int px = 0; px < 15; px++) begin
          q.x   = 20 + x * 15 + px;
          q.y   = y * 15 + py;
          q.c   = exp_colour(x, y, p, px, py);
          q.cyc = ld + 1 + py * 15 + px;
          pq.push_back(q);
        end
      dq.push_back(ld + 226);
      last_done = ld + 226;
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while ((pq.size() != 0 || dq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (pq.size() != 0 || dq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pixels and %0d done pulses outstanding, expected 0 and 0",
               pq.size(), dq.size());
    end
    repeat (3) tick();
  endtask

  function automatic int board_piece(int x, int y);
    int back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    if (y == 0) return back[x] + 6;
    if (y == 1) return 7;
    if (y == 6) return 1;
    if (y == 7) return back[x];
    return 0;
  endfunction

  always @(negedge clk) begin
    if (resetn) begin
      if (plot) begin
        n_cmp++;
        if (pq.size() == 0) begin
          n_bad++;
          $display("FAIL pixel: got plot at cyc %0d x=%0d y=%0d, expected no plot",
                   cyc, vga_x, vga_y);
        end else begin
          e = pq.pop_front();
          if (int'(vga_x) != e.x || int'(vga_y) != e.y || colour !== e.c || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL pixel: got x=%0d y=%0d c=%b cyc=%0d, expected x=%0d y=%0d c=%b cyc=%0d",
                     vga_x, vga_y, colour, cyc, e.x, e.y, e.c, e.cyc);
          end
        end
      end
      if (done) begin
        n_cmp++;
        if (dq.size() == 0) begin
          n_bad++;
          $display("FAIL done: got pulse at cyc %0d, expected none", cyc);
        end else begin
          ed = dq.pop_front();
          if (cyc != ed) begin
            n_bad++;
            $display("FAIL done: got pulse at cyc %0d, expected cyc %0d", cyc, ed);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int target;
    int budget;
    resetn = 1'b0;
    wr_en  = 1'b0;
    sq_x   = '0;
    sq_y   = '0;
    piece  = '0;
    repeat (3) tick();
    chk("rst_plot", int'(plot), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_ready", int'(ready), 1);
    chk("rst_vga_x", int'(vga_x), 0);
    chk("rst_vga_y", int'(vga_y), 0);
    chk("rst_colour", int'(colour), 0);
    resetn = 1'b1;
    repeat (2) tick();

    send(0, 0, 0);
    wait_idle(400);
    send(1, 0, 6);
    wait_idle(400);
    send(7, 7, 10);
    wait_idle(400);

    // LOAD pops the first entry, so three writes fit and the fourth
    // back-to-back write is the first one to find the FIFO full.
    send(2, 3, 1);
    send(3, 3, 13);
    send(4, 4, 5);
    send(5, 5, 7);
    chk("overflow_set", int'(overflow), 1);
    wait_idle(1000);
    chk("overflow_sticky", int'(overflow), 1);

    send(3, 2, 4);
    target = loads[loads.size() - 1] + 1 + 100;
    while (cyc < target) tick();
    #1;
    resetn = 1'b0;
    #1;
    pq.delete();
    dq.delete();
    loads.delete();
    last_done = -100;
    chk("mid_rst_plot", int'(plot), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_ready", int'(ready), 1);
    chk("mid_rst_overflow", int'(overflow), 0);
    chk("mid_rst_vga_x", int'(vga_x), 0);
    repeat (2) tick();
    resetn = 1'b1;
    repeat (240) tick();
    chk("post_rst_ready", int'(ready), 1);

    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        budget = 0;
        while (!ready && budget < 1000) begin
          tick();
          budget++;
        end
        if (budget >= 1000) chk("board_ready_wait", int'(ready), 1);
        send(x, y, board_piece(x, y));
      end
    wait_idle(1000);
    chk("board_overflow", int'(overflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
